// File: rtl/arb_age_pkg.sv
// Shared types and helpers for the age-based arbiter.
package arb_age_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam bit ACT_HIGH = 1'b1;
  localparam bit SEL_MAX  = 1'b0;

  // Selection key is {candidate bit, age}.
  function automatic int key_w(input int age_w);
    return age_w + 1;
  endfunction

endpackage

// File: rtl/arb_age_sel_minmax.sv
// Combinational max/min selector over IN values; ties resolve to the lowest index.
module sel_minmax #(
  parameter bit MINMAX_ = 1'b0,
  parameter int IN      = 8,
  parameter int DATA    = 5,
  parameter bit ACT     = 1'b1,
  localparam int IW     = (IN > 1) ? $clog2(IN) : 1
) (
  input  logic [IN-1:0][DATA-1:0] in_data,
  output logic [IW-1:0]           out_idx,
  output logic [IN-1:0]           out_vec,
  output logic [DATA-1:0]         out_val
);

  logic [IW-1:0]   best_idx;
  logic [DATA-1:0] best_val;
  logic [IN-1:0]   onehot;

  // Strict comparison keeps the earlier (lower) index on equal values.
  always_comb begin
    best_idx = '0;
    best_val = in_data[0];
    for (int i = 1; i < IN; i++) begin
      if (MINMAX_ == 1'b0 ? (in_data[i] > best_val) : (in_data[i] < best_val)) begin
        best_idx = IW'(i);
        best_val = in_data[i];
      end
    end
  end

  always_comb begin
    onehot  = '0;
    onehot[best_idx] = 1'b1;
    out_vec = ACT ? onehot : ~onehot;
    out_idx = best_idx;
    out_val = best_val;
  end

endmodule

// File: rtl/arb_age.sv
// Age-based arbiter: grants the longest-waiting requester and holds the grant
// until release, requester drop or hold timeout.
module arb_age
  import arb_age_pkg::*;
#(
  parameter int  REQ  = 8,
  parameter int  AGE  = 4,
  parameter int  HOLD = 16,
  localparam int IDX  = $clog2(REQ)
) (
  input  logic           clk,
  input  logic           reset_,
  input  logic [REQ-1:0] req,
  input  logic           rel,
  output logic [REQ-1:0] gnt,
  output logic [IDX-1:0] gnt_idx,
  output logic           busy,
  output logic           timeout
);

  localparam int KW = key_w(AGE);
  localparam int HW = $clog2(HOLD + 1);

  arb_state_e               state_q, state_d;
  logic [REQ-1:0][AGE-1:0]  age_q, age_d;
  logic [REQ-1:0]           gnt_q, gnt_d;
  logic [IDX-1:0]           gnt_idx_q, gnt_idx_d;
  logic                     busy_q, busy_d;
  logic                     timeout_q, timeout_d;
  logic [HW-1:0]            hold_q, hold_d;

  logic [REQ-1:0]           cand;
  logic [REQ-1:0][KW-1:0]   keys;
  logic [IDX-1:0]           win_idx;
  logic [REQ-1:0]           win_vec;
  logic [KW-1:0]            win_val;
  logic                     win_vld;
  logic                     drop, expire, end_c;

  // The current holder is masked so an end condition can hand over directly.
  always_comb begin
    cand = req & ~gnt_q;
    for (int i = 0; i < REQ; i++) begin
      keys[i] = {cand[i], age_q[i]};
    end
  end

  sel_minmax #(
    .MINMAX_ (SEL_MAX),
    .IN      (REQ),
    .DATA    (KW),
    .ACT     (ACT_HIGH)
  ) u_sel (
    .in_data (keys),
    .out_idx (win_idx),
    .out_vec (win_vec),
    .out_val (win_val)
  );

  assign win_vld = win_val[KW-1];
  assign drop    = ~req[gnt_idx_q];
  assign expire  = (hold_q == HW'(HOLD - 1));
  assign end_c   = rel | drop | expire;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    busy_d    = busy_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          gnt_d     = win_vec;
          gnt_idx_d = win_idx;
          busy_d    = 1'b1;
          hold_d    = '0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (end_c) begin
          timeout_d = expire & ~rel & ~drop;
          hold_d    = '0;
          if (win_vld) begin
            gnt_d     = win_vec;
            gnt_idx_d = win_idx;
          end else begin
            gnt_d     = '0;
            gnt_idx_d = '0;
            busy_d    = 1'b0;
            state_d   = IDLE;
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        gnt_d     = '0;
        gnt_idx_d = '0;
        busy_d    = 1'b0;
        hold_d    = '0;
        state_d   = IDLE;
      end
    endcase
  end

  // Ages restart for idle requesters and for whoever holds or is about to hold.
  always_comb begin
    for (int i = 0; i < REQ; i++) begin
      if (!req[i] || gnt_q[i] || gnt_d[i]) begin
        age_d[i] = '0;
      end else if (age_q[i] != {AGE{1'b1}}) begin
        age_d[i] = age_q[i] + AGE'(1);
      end else begin
        age_d[i] = age_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q   <= IDLE;
      age_q     <= '0;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      age_q     <= age_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      hold_q    <= hold_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = gnt_idx_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_arb_age.sv
// Directed bench for arb_age with REQ=4, AGE=3, HOLD=8.
module tb_arb_age;

  logic       clk = 1'b0;
  logic       reset_;
  logic [3:0] req;
  logic       rel;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arb_age #(
    .REQ  (4),
    .AGE  (3),
    .HOLD (8)
  ) dut (
    .clk     (clk),
    .reset_  (reset_),
    .req     (req),
    .rel     (rel),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .busy    (busy),
    .timeout (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] eg, input logic [1:0] ei,
                         input logic eb, input logic et);
    chk({tag, ".gnt"},     32'(gnt),     32'(eg));
    chk({tag, ".gnt_idx"}, 32'(gnt_idx), 32'(ei));
    chk({tag, ".busy"},    32'(busy),    32'(eb));
    chk({tag, ".timeout"}, 32'(timeout), 32'(et));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset_ = 1'b0;
    req    = 4'b0000;
    rel    = 1'b0;
    #2;
    chk_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    step(2);
    chk_out("reset_hold", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset_ = 1'b1;
    step(1);
    chk_out("idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Single request, release two cycles later
    req = 4'b0001;
    step(1);
    chk_out("single_t1", 4'b0001, 2'd0, 1'b1, 1'b0);
    step(2);
    chk_out("single_t3", 4'b0001, 2'd0, 1'b1, 1'b0);
    rel = 1'b1;
    req = 4'b0000;
    step(1);
    rel = 1'b0;
    chk_out("single_t4", 4'b0000, 2'd0, 1'b0, 1'b0);
    rel = 1'b1;
    step(1);
    rel = 1'b0;
    chk_out("rel_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Tie break and back-to-back handover
    req = 4'b1010;
    step(1);
    chk_out("tie_first", 4'b0010, 2'd1, 1'b1, 1'b0);
    rel = 1'b1;
    step(1);
    rel = 1'b0;
    chk_out("tie_second", 4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b0000;
    step(1);
    chk_out("tie_done", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Aging: req[3] ages to 5, req[1] to 2, then release
    req = 4'b0001;
    step(1);
    chk_out("age_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b1001;
    step(3);
    req = 4'b1011;
    step(2);
    chk_out("age_wait", 4'b0001, 2'd0, 1'b1, 1'b0);
    rel = 1'b1;
    step(1);
    rel = 1'b0;
    chk_out("age_win", 4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b0000;
    step(1);
    chk_out("age_done", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Hold timeout with a single requester
    req = 4'b0001;
    step(1);
    chk_out("to_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
    step(7);
    chk_out("to_last", 4'b0001, 2'd0, 1'b1, 1'b0);
    step(1);
    chk_out("to_expire", 4'b0000, 2'd0, 1'b0, 1'b1);
    step(1);
    chk_out("to_regrant", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0000;
    step(2);
    chk_out("to_done", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Hold timeout hands over to a waiter
    req = 4'b0011;
    step(1);
    chk_out("to2_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
    step(7);
    chk_out("to2_last", 4'b0001, 2'd0, 1'b1, 1'b0);
    step(1);
    chk_out("to2_switch", 4'b0010, 2'd1, 1'b1, 1'b1);
    step(1);
    chk_out("to2_after", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b0000;
    step(2);
    chk_out("to2_done", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Release coinciding with hold expiry counts as a release
    req = 4'b0001;
    step(8);
    chk_out("relto_last", 4'b0001, 2'd0, 1'b1, 1'b0);
    rel = 1'b1;
    step(1);
    rel = 1'b0;
    chk_out("relto_end", 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b0000;
    step(2);

    // Requester drop; saturated waiters stay at age 7
    req = 4'b0001;
    step(1);
    chk_out("drop_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0111;
    step(7);
    chk_out("drop_wait", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0110;
    step(1);
    chk_out("drop_sw1", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b0101;
    step(1);
    chk_out("drop_sat", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b0000;
    step(2);
    chk_out("drop_done", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a grant
    req = 4'b0001;
    step(1);
    chk_out("rst_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
    #2;
    reset_ = 1'b0;
    #1;
    chk_out("rst_async", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset_ = 1'b1;
    req    = 4'b0100;
    step(1);
    chk_out("rst_regrant", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b0000;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arb_age.md
# arb_age

Age-based arbiter that shares one resource among REQ requesters by granting the longest-waiting one. Each requester owns a saturating wait counter; a max-selector tree picks the oldest active request, and a two-state FSM holds the grant until release, requester drop, or hold timeout. It sits in front of any shared unit, such as a port, buffer or functional unit, that needs fair, starvation-free sharing.

## Interface
- REQ, 8, number of requesters (≥2)
- AGE, 4, wait-counter width; saturates at 2^AGE-1
- HOLD, 16, maximum grant length in cycles (≥1)
- IDX, $clog2(REQ), derived; grant index width
- clk  in  1  clock
- reset_  in  1  asynchronous, active-low reset
- req  in  REQ  per-requester request, active-high, level-sensitive
- rel  in  1  release of current grant by the holder, active-high
- gnt  out  REQ  one-hot grant, registered
- gnt_idx  out  IDX  index of granted requester; 0 when idle
- busy  out  1  a grant is held
- timeout  out  1  one-cycle pulse when a grant is revoked by HOLD expiry

## Operation
- Reset values: gnt=0, gnt_idx=0, busy=0, timeout=0, all ages=0, hold counter=0, state IDLE.
- Age update, every cycle, per requester i:
  - age[i] clears to 0 if req[i]=0, or if i is granted in this or the next cycle.
  - Otherwise age[i] increments by 1, saturating at 2^AGE-1.
- Selection key per requester: {cand[i], age[i]}, AGE+1 bits.
  - cand[i] = req[i] & ~mask[i]; mask marks the requester currently granted.
  - Maximum key wins. On a tie, the lowest index wins.
  - A win is valid only if the winning cand bit is 1.
- FSM states:
  - IDLE: if any cand, load gnt/gnt_idx with the winner next cycle, set busy, clear the hold counter, go to BUSY. Otherwise stay.
  - BUSY: an end condition is rel=1, or req[gnt_idx]=0, or hold counter = HOLD-1.
    - On an end condition, if another cand exists (current holder masked), the grant switches directly to that winner next cycle and the FSM stays in BUSY with the hold counter cleared.
    - On an end condition with no other cand, gnt=0, busy=0, go to IDLE.
    - With no end condition, the hold counter increments.
- timeout pulses in the cycle after an end caused solely by HOLD expiry, meaning neither rel nor a req drop occurred.
- The revoked holder keeps requesting with age 0. It is re-eligible from the next selection.
- rel while in IDLE is ignored.

## Timing
- Request to grant: req[i] high at cycle t in IDLE gives gnt[i] at t+1.
- Release to next grant: rel at t gives the new gnt at t+1, with no idle bubble. If there is no waiter, gnt=0 at t+1.
- Maximum grant length is HOLD cycles. For HOLD=1, every grant lasts exactly one cycle.
- The worst-case wait is bounded: a requester reaches maximum age and then competes only on index among saturated peers.
- Asynchronous reset mid-grant drops gnt, busy and timeout immediately, with no release handshake.
- Simultaneous rel and HOLD expiry count as a rel end; timeout stays 0.
- All outputs come from flops; there is no combinational path from req or rel to the outputs.

## Structure
- The shared package holds the state typedef (IDLE, BUSY) and the key width helper (AGE+1).
- sel_minmax is the single sub-module, instantiated with MINMAX_=0, IN=REQ, DATA=AGE+1, ACT=High.
  - It supplies the winner index and vector.
  - Its out value MSB is the valid bit.
- The block's own logic is the age counters, mask, hold counter, FSM, and output registers.

## Test plan
All scenarios use REQ=4, AGE=3, HOLD=8.
- Single request: req=0001 at t0 → gnt=0001, gnt_idx=0, busy=1 at t1. rel at t3 → gnt=0, busy=0 at t4.
- Tie break: req=1010 together from IDLE → gnt=0010 first. On rel, gnt=1000 the next cycle with no gap.
- Aging fairness:
  - req[3] waits 5 cycles while req[0] is held.
  - req[1] rises 2 cycles before rel.
  - On rel → gnt=1000, since age 5 beats age 2.
- Hold timeout:
  - req=0001 held with no rel → gnt drops after exactly 8 cycles and timeout pulses once.
  - With req=0011, gnt moves to 0010 instead.
- Requester drop: the granted req falls with no rel → grant ends next cycle, same as a release. The age of a saturating waiter (7) does not wrap.
- Reset mid-grant: reset_ low while busy → gnt=0, busy=0 asynchronously. After release of reset, req=0100 → gnt=0100 one cycle later.
